alu_ctrl_pipe: RTL and testbench

Registered, handshaked successor to the combinational ALU-control decoder. It decodes opcode/funct into the 4-bit ALU control code and adds decodes for xor/xori, sra, sltu/sltiu and mult/div. It sequences multi-cycle mult/div ops with an internal counter and busy stall. It sits between the ID stage and the EX stage and uses valid/ready handshakes on both sides.

---
 rtl/alu_ctrl_pipe.sv | 156 +++++++++++++++
 tb/tb_alu_ctrl_pipe.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_pipe.sv
// Registered, handshaked ALU-control decoder between ID and EX.
// Multi-cycle mult/div ops are sequenced by a down-counter that stalls the input side.
module alu_ctrl_pipe #(
  parameter int unsigned MULDIV_CYCLES = 32,
  parameter bit          EN_MULDIV     = 1'b1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       flush,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] alu_ctrl,
  output logic       is_muldiv,
  output logic       illegal,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    OUT    = 2'd1,
    MD_RUN = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       alu_ctrl_q, alu_ctrl_d;
  logic             is_muldiv_q, is_muldiv_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [3:0] dec_ctrl;
  logic       dec_illegal;
  logic       dec_muldiv;
  logic       accept;

  always_comb begin
    dec_ctrl    = 4'b1111;
    dec_illegal = 1'b0;
    dec_muldiv  = 1'b0;
    unique case (opcode)
      6'b001000, 6'b100011, 6'b101011: dec_ctrl = 4'b0010;
      6'b001100: dec_ctrl = 4'b0000;
      6'b001101: dec_ctrl = 4'b0001;
      6'b001110: dec_ctrl = 4'b1001;
      6'b001010: dec_ctrl = 4'b1000;
      6'b001011: dec_ctrl = 4'b1011;
      6'b001111: dec_ctrl = 4'b1010;
      6'b000010, 6'b000011, 6'b000100, 6'b000101: dec_ctrl = 4'b1111;
      6'b000000: begin
        unique case (funct)
          6'b100000: dec_ctrl = 4'b0010;
          6'b100010: dec_ctrl = 4'b0011;
          6'b100100: dec_ctrl = 4'b0000;
          6'b100101: dec_ctrl = 4'b0001;
          6'b100110: dec_ctrl = 4'b1001;
          6'b100111: dec_ctrl = 4'b0100;
          6'b101010: dec_ctrl = 4'b1000;
          6'b101011: dec_ctrl = 4'b1011;
          6'b000000: dec_ctrl = 4'b0101;
          6'b000010: dec_ctrl = 4'b0110;
          6'b000011: dec_ctrl = 4'b0111;
          6'b001000: dec_ctrl = 4'b1111;
          6'b011000, 6'b011001: begin
            if (EN_MULDIV) begin
              dec_ctrl   = 4'b1100;
              dec_muldiv = 1'b1;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          6'b011010, 6'b011011: begin
            if (EN_MULDIV) begin
              dec_ctrl   = 4'b1101;
              dec_muldiv = 1'b1;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
  end

  assign in_ready = !flush && (state_q != MD_RUN) && ((state_q != OUT) || out_ready);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    alu_ctrl_d  = alu_ctrl_q;
    is_muldiv_d = is_muldiv_q;
    illegal_d   = illegal_q;
    cnt_d       = cnt_q;
    // flush clears everything except alu_ctrl, which keeps its last value
    if (flush) begin
      state_d     = IDLE;
      is_muldiv_d = 1'b0;
      illegal_d   = 1'b0;
      cnt_d       = '0;
    end else begin
      unique case (state_q)
        IDLE, OUT: begin
          if (accept) begin
            alu_ctrl_d  = dec_ctrl;
            illegal_d   = dec_illegal;
            is_muldiv_d = 1'b0;
            if (dec_muldiv) begin
              state_d = MD_RUN;
              cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
            end else begin
              state_d = OUT;
            end
          end else if (state_q == OUT && out_ready) begin
            state_d = IDLE;
          end
        end
        MD_RUN: begin
          cnt_d = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d     = OUT;
            is_muldiv_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      alu_ctrl_q  <= 4'b1111;
      is_muldiv_q <= 1'b0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      alu_ctrl_q  <= alu_ctrl_d;
      is_muldiv_q <= is_muldiv_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid = (state_q == OUT);
  assign busy      = (state_q == MD_RUN);
  assign alu_ctrl  = alu_ctrl_q;
  assign is_muldiv = is_muldiv_q;
  assign illegal   = illegal_q;

endmodule

// File: tb/tb_alu_ctrl_pipe.sv
// Self-checking bench for alu_ctrl_pipe: directed scenarios plus a randomized run
// against a transaction-level reference model.
module tb_alu_ctrl_pipe;

  localparam int unsigned CYC = 4;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       flush;
  logic       out_ready;

  logic       in_ready, out_valid, is_muldiv, illegal, busy;
  logic [3:0] alu_ctrl;
  logic       in_ready2, out_valid2, is_muldiv2, illegal2, busy2;
  logic [3:0] alu_ctrl2;

  int errors = 0;
  int checks = 0;

  alu_ctrl_pipe #(.MULDIV_CYCLES(CYC), .EN_MULDIV(1'b1), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct(funct), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl), .is_muldiv(is_muldiv),
    .illegal(illegal), .busy(busy)
  );

  alu_ctrl_pipe #(.MULDIV_CYCLES(CYC), .EN_MULDIV(1'b0), .CNT_W(8)) dut_nomd (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready2),
    .opcode(opcode), .funct(funct), .flush(flush), .out_valid(out_valid2),
    .out_ready(out_ready), .alu_ctrl(alu_ctrl2), .is_muldiv(is_muldiv2),
    .illegal(illegal2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode straight from the opcode/funct table.
  task automatic ref_decode(input logic [5:0] op, input logic [5:0] fn, input bit en,
                            output logic [3:0] c, output logic ill, output logic md);
    c = 4'b1111; ill = 1'b0; md = 1'b0;
    case (op)
      6'o10, 6'o43, 6'o53: c = 4'b0010;
      6'o14: c = 4'b0000;
      6'o15: c = 4'b0001;
      6'o16: c = 4'b1001;
      6'o12: c = 4'b1000;
      6'o13: c = 4'b1011;
      6'o17: c = 4'b1010;
      6'o02, 6'o03, 6'o04, 6'o05: c = 4'b1111;
      6'o00: begin
        case (fn)
          6'b100000: c = 4'b0010;
          6'b100010: c = 4'b0011;
          6'b100100: c = 4'b0000;
          6'b100101: c = 4'b0001;
          6'b100110: c = 4'b1001;
          6'b100111: c = 4'b0100;
          6'b101010: c = 4'b1000;
          6'b101011: c = 4'b1011;
          6'b000000: c = 4'b0101;
          6'b000010: c = 4'b0110;
          6'b000011: c = 4'b0111;
          6'b001000: c = 4'b1111;
          6'b011000, 6'b011001: if (en) begin c = 4'b1100; md = 1'b1; end else ill = 1'b1;
          6'b011010, 6'b011011: if (en) begin c = 4'b1101; md = 1'b1; end else ill = 1'b1;
          default: ill = 1'b1;
        endcase
      end
      default: ill = 1'b1;
    endcase
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0; opcode = '0; funct = '0; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    rst_n = 1'b0;
    #7;
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_ctrl !== 4'b1111 || is_muldiv !== 1'b0 ||
        illegal !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got v=%b c=%b md=%b ill=%b busy=%b, want v=0 c=1111 md=0 ill=0 busy=0",
               out_valid, alu_ctrl, is_muldiv, illegal, busy);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_back_to_back();
    do_reset();
    in_valid = 1'b1; opcode = 6'o00; funct = 6'b100010; out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_idle: got %b want 1", in_ready); end
    cyc();
    opcode = 6'b001101;
    #1;
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b0011 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL b2b_sub: got v=%b c=%b ill=%b, want v=1 c=0011 ill=0", out_valid, alu_ctrl, illegal);
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_out: got %b want 1", in_ready); end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b0001) begin
      errors++;
      $display("FAIL b2b_ori: got v=%b c=%b, want v=1 c=0001", out_valid, alu_ctrl);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_muldiv();
    do_reset();
    in_valid = 1'b1; opcode = 6'o00; funct = 6'b011000; out_ready = 1'b1;
    cyc();
    opcode = 6'b001000;
    for (int i = 0; i < CYC - 1; i++) begin
      #1;
      checks++;
      if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL muldiv_busy[%0d]: got busy=%b rdy=%b v=%b, want 1 0 0", i, busy, in_ready, out_valid);
      end
      if (i == CYC - 2) in_valid = 1'b0;
      cyc();
    end
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b1100 || is_muldiv !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL muldiv_done: got v=%b c=%b md=%b busy=%b, want 1 1100 1 0",
               out_valid, alu_ctrl, is_muldiv, busy);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL muldiv_drain: got v=%b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    do_reset();
    out_ready = 1'b0; in_valid = 1'b1; opcode = 6'b001111;
    cyc();
    opcode = 6'b001000;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (out_valid !== 1'b1 || alu_ctrl !== 4'b1010 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d]: got v=%b c=%b rdy=%b, want 1 1010 0", i, out_valid, alu_ctrl, in_ready);
      end
      cyc();
    end
    out_ready = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b1010 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got v=%b c=%b rdy=%b, want 1 1010 1", out_valid, alu_ctrl, in_ready);
    end
    cyc();
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_no_dup: got v=%b want 0", out_valid); end
  endtask

  task automatic test_illegal();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; opcode = 6'b111111;
    cyc();
    opcode = 6'b000010;
    #1;
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b1111 || illegal !== 1'b1) begin
      errors++;
      $display("FAIL illegal_op: got v=%b c=%b ill=%b, want 1 1111 1", out_valid, alu_ctrl, illegal);
    end
    cyc();
    opcode = 6'o00; funct = 6'b011010;
    #1;
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b1111 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL legal_jump: got v=%b c=%b ill=%b, want 1 1111 0", out_valid, alu_ctrl, illegal);
    end
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid2 !== 1'b1 || alu_ctrl2 !== 4'b1111 || illegal2 !== 1'b1 || busy2 !== 1'b0) begin
      errors++;
      $display("FAIL nomd_div: got v=%b c=%b ill=%b busy=%b, want 1 1111 1 0",
               out_valid2, alu_ctrl2, illegal2, busy2);
    end
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL md_div_busy: got busy=%b want 1", busy); end
    for (int i = 0; i < CYC; i++) cyc();
  endtask

  task automatic test_flush();
    do_reset();
    out_ready = 1'b1; in_valid = 1'b1; opcode = 6'o00; funct = 6'b011010;
    cyc();
    in_valid = 1'b0;
    cyc();
    flush = 1'b1; in_valid = 1'b1; opcode = 6'b001000;
    #1;
    checks++;
    if (in_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL flush_ready: got rdy=%b busy=%b, want 0 1", in_ready, busy);
    end
    cyc();
    flush = 1'b0; in_valid = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || illegal !== 1'b0 || is_muldiv !== 1'b0 ||
        alu_ctrl !== 4'b1101) begin
      errors++;
      $display("FAIL flush_clear: got busy=%b v=%b ill=%b md=%b c=%b, want 0 0 0 0 1101",
               busy, out_valid, illegal, is_muldiv, alu_ctrl);
    end
    cyc();
    cyc();
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL flush_discard: got v=%b busy=%b, want 0 0", out_valid, busy);
    end
    in_valid = 1'b1; opcode = 6'b001010;
    cyc();
    in_valid = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b1 || alu_ctrl !== 4'b1000 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL flush_next_op: got v=%b c=%b ill=%b, want 1 1000 0", out_valid, alu_ctrl, illegal);
    end
    cyc();
  endtask

  task automatic test_async_reset();
    do_reset();
    in_valid = 1'b1; opcode = 6'o00; funct = 6'b011001; out_ready = 1'b1;
    cyc();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0 || alu_ctrl !== 4'b1111) begin
      errors++;
      $display("FAIL arst_mdrun: got busy=%b v=%b c=%b, want 0 0 1111", busy, out_valid, alu_ctrl);
    end
    #1;
    rst_n = 1'b1;
    cyc();
    in_valid = 1'b1; opcode = 6'b111110; out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || alu_ctrl !== 4'b1111 || illegal !== 1'b0 || is_muldiv !== 1'b0) begin
      errors++;
      $display("FAIL arst_out: got v=%b c=%b ill=%b md=%b, want 0 1111 0 0",
               out_valid, alu_ctrl, illegal, is_muldiv);
    end
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    cyc();
  endtask

  task automatic test_random();
    logic [5:0] ops [0:13];
    logic [5:0] fns [0:15];
    logic       m_valid, m_ill, m_md;
    logic [3:0] m_ctrl;
    int         m_wait;
    logic [3:0] dc;
    logic       dill, dmd, exp_ready, acc;
    ops = '{6'o10, 6'o43, 6'o53, 6'o14, 6'o15, 6'o16, 6'o12, 6'o13, 6'o17,
            6'o02, 6'o05, 6'o77, 6'o01, 6'o00};
    fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
            6'b101010, 6'b101011, 6'b000000, 6'b000010, 6'b000011, 6'b001000,
            6'b011000, 6'b011011, 6'b111111, 6'b000001};
    do_reset();
    m_valid = 1'b0; m_ill = 1'b0; m_md = 1'b0; m_ctrl = 4'b1111; m_wait = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      opcode    = ($urandom_range(0, 2) == 0) ? 6'o00 : ops[$urandom_range(0, 13)];
      funct     = fns[$urandom_range(0, 15)];
      #1;
      exp_ready = (m_wait == 0) && (!m_valid || out_ready);
      checks++;
      if (in_ready !== exp_ready || out_valid !== m_valid || busy !== (m_wait > 0)) begin
        errors++;
        $display("FAIL rand_hs[%0d]: got rdy=%b v=%b busy=%b, want %b %b %b",
                 n, in_ready, out_valid, busy, exp_ready, m_valid, m_wait > 0);
      end
      if (m_valid) begin
        checks++;
        if (alu_ctrl !== m_ctrl || illegal !== m_ill || is_muldiv !== m_md) begin
          errors++;
          $display("FAIL rand_data[%0d]: got c=%b ill=%b md=%b, want %b %b %b",
                   n, alu_ctrl, illegal, is_muldiv, m_ctrl, m_ill, m_md);
        end
      end
      acc = in_valid && exp_ready;
      cyc();
      if (acc) begin
        ref_decode(opcode, funct, 1'b1, dc, dill, dmd);
        m_ctrl = dc; m_ill = dill; m_md = 1'b0;
        if (dmd) begin
          m_wait = CYC - 1; m_valid = 1'b0;
        end else begin
          m_valid = 1'b1;
        end
      end else if (m_wait > 0) begin
        m_wait--;
        if (m_wait == 0) begin m_valid = 1'b1; m_md = 1'b1; end
      end else if (m_valid && out_ready) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    rst_n = 1'b1;
    in_valid = 1'b0; opcode = '0; funct = '0; flush = 1'b0; out_ready = 1'b1;
    test_reset();
    test_back_to_back();
    test_muldiv();
    test_backpressure();
    test_illegal();
    test_flush();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
